// File: rtl/dm_result_checker.sv
// Post-run data-memory checker: reads operands A/B and ten result slots, recomputes
// the expected ALU results and reports a per-slot error mask and error count.
module dm_result_checker #(
    parameter logic [7:0] BASE_ADDR  = 8'd0,
    parameter logic [9:0] CHECK_MASK = 10'b11_1111_1111
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic [7:0] MemAddr,
    output logic       MemRdEn,
    input  logic [7:0] MemData,
    output logic       Busy,
    output logic       Finished,
    output logic [9:0] ErrorMask,
    output logic [3:0] ErrCount
);

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned NUM_SLOTS = 10;
    localparam int unsigned LAST_TAG  = 11;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       n_q, n_d;
    logic                   start_q, start_d;
    logic                   start_vld_q, start_vld_d;
    logic [DATA_W-1:0]      mem_addr_q, mem_addr_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [TAG_W-1:0]       rd_tag_q, rd_tag_d;
    logic                   cmp_vld_q, cmp_vld_d;
    logic [TAG_W-1:0]       cmp_tag_q, cmp_tag_d;
    logic [DATA_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]      b_q, b_d;
    logic                   busy_q, busy_d;
    logic                   finished_q, finished_d;
    logic [NUM_SLOTS-1:0]   error_mask_q, error_mask_d;
    logic [CNT_W-1:0]       err_count_q, err_count_d;

    logic                   start_rise_c;
    logic [TAG_W-1:0]       slot_idx_c;
    logic [DATA_W-1:0]      exp_c;

    // start_vld_q blocks a spurious rise when Start is already high as reset releases
    assign start_rise_c = Start && !start_q && start_vld_q;
    assign slot_idx_c   = cmp_tag_q - TAG_W'(2);

    // Reference ALU result for the slot currently returning from memory
    always_comb begin
        exp_c = '0;
        case (slot_idx_c)
            4'd0:    exp_c = a_q + b_q;
            4'd1:    exp_c = a_q - b_q;
            4'd2:    exp_c = a_q & b_q;
            4'd3:    exp_c = a_q ^ b_q;
            4'd4:    exp_c = a_q | b_q;
            4'd5:    exp_c = ~a_q;
            4'd6:    exp_c = {7'b0, ^a_q};
            4'd7:    exp_c = a_q << 1;
            4'd8:    exp_c = a_q >> 1;
            4'd9:    exp_c = a_q + DATA_W'(1);
            default: exp_c = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        start_d      = Start;
        start_vld_d  = 1'b1;
        mem_addr_d   = mem_addr_q;
        mem_rd_en_d  = 1'b0;
        rd_tag_d     = rd_tag_q;
        cmp_vld_d    = mem_rd_en_q;
        cmp_tag_d    = rd_tag_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        finished_d   = finished_q;
        error_mask_d = error_mask_q;
        err_count_d  = err_count_q;

        // Returning read data: tag 0/1 capture operands, 2..11 are compared
        if (cmp_vld_q) begin
            if (cmp_tag_q == TAG_W'(0)) begin
                a_d = MemData;
            end else if (cmp_tag_q == TAG_W'(1)) begin
                b_d = MemData;
            end else if ((MemData != exp_c) && CHECK_MASK[slot_idx_c]
                         && !error_mask_q[slot_idx_c]) begin
                error_mask_d[slot_idx_c] = 1'b1;
                if (err_count_q < CNT_W'(NUM_SLOTS)) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_rise_c) begin
                    state_d      = ISSUE;
                    n_d          = '0;
                    busy_d       = 1'b1;
                    finished_d   = 1'b0;
                    error_mask_d = '0;
                    err_count_d  = '0;
                end
            end
            ISSUE: begin
                mem_rd_en_d = 1'b1;
                mem_addr_d  = BASE_ADDR + DATA_W'(n_q);
                rd_tag_d    = n_q;
                n_d         = n_q + TAG_W'(1);
                if (n_q == TAG_W'(LAST_TAG)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cmp_vld_q && (cmp_tag_q == TAG_W'(LAST_TAG))) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    finished_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            start_q      <= 1'b0;
            start_vld_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            rd_tag_q     <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_tag_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            error_mask_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            start_q      <= start_d;
            start_vld_q  <= start_vld_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_en_q  <= mem_rd_en_d;
            rd_tag_q     <= rd_tag_d;
            cmp_vld_q    <= cmp_vld_d;
            cmp_tag_q    <= cmp_tag_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            error_mask_q <= error_mask_d;
            err_count_q  <= err_count_d;
        end
    end

    assign MemAddr   = mem_addr_q;
    assign MemRdEn   = mem_rd_en_q;
    assign Busy      = busy_q;
    assign Finished  = finished_q;
    assign ErrorMask = error_mask_q;
    assign ErrCount  = err_count_q;

endmodule
